// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types for hazard control
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hazard_state_t;

    // Wide enough for MDU_LATENCY-2 with MDU_LATENCY up to 15
    localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/forward_sel.sv
// rtl/forward_sel.sv - execute operand forwarding select for one source register
module forward_sel
    import pipeline_pkg::*;
#(
    parameter int RF_ADDR_W = 5
) (
    input  logic [RF_ADDR_W-1:0] src,
    input  logic [RF_ADDR_W-1:0] m_wa,
    input  logic                 m_rf_we,
    input  logic [RF_ADDR_W-1:0] w_wa,
    input  logic                 w_rf_we,
    output fwd_sel_t             sel
);

    // Register 0 is hardwired, so it never forwards; the younger M result wins
    always_comb begin
        sel = FWD_RF;
        if (m_rf_we && (m_wa != '0) && (m_wa == src)) begin
            sel = FWD_M;
        end else if (w_rf_we && (w_wa != '0) && (w_wa == src)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush, forwarding and MDU occupancy control
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int RF_ADDR_W   = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [RF_ADDR_W-1:0] d_rs,
    input  logic [RF_ADDR_W-1:0] d_rt,
    input  logic                 d_uses_rs,
    input  logic                 d_uses_rt,
    input  logic [RF_ADDR_W-1:0] e_rs,
    input  logic [RF_ADDR_W-1:0] e_rt,
    input  logic [RF_ADDR_W-1:0] e_wa,
    input  logic                 e_rf_we,
    input  logic                 e_is_load,
    input  logic                 e_mdu_start,
    input  logic [RF_ADDR_W-1:0] m_wa,
    input  logic                 m_rf_we,
    input  logic                 m_branch_taken,
    input  logic [RF_ADDR_W-1:0] w_wa,
    input  logic                 w_rf_we,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_m,
    output fwd_sel_t             fwd_a,
    output fwd_sel_t             fwd_b,
    output logic                 mdu_busy,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    hazard_state_t        state, next_state;
    logic [MDU_CNT_W-1:0] cnt, next_cnt;
    logic                 lu;
    fwd_sel_t             sel_a, sel_b;

    forward_sel #(.RF_ADDR_W(RF_ADDR_W)) u_fwd_a (
        .src(e_rs), .m_wa(m_wa), .m_rf_we(m_rf_we),
        .w_wa(w_wa), .w_rf_we(w_rf_we), .sel(sel_a)
    );

    forward_sel #(.RF_ADDR_W(RF_ADDR_W)) u_fwd_b (
        .src(e_rt), .m_wa(m_wa), .m_rf_we(m_rf_we),
        .w_wa(w_wa), .w_rf_we(w_rf_we), .sel(sel_b)
    );

    assign lu = e_is_load && e_rf_we && (e_wa != '0) &&
                ((d_uses_rs && (d_rs == e_wa)) || (d_uses_rt && (d_rt == e_wa)));

    assign fwd_a    = reset ? sel_a : FWD_RF;
    assign fwd_b    = reset ? sel_b : FWD_RF;
    assign mdu_busy = reset && (state == MDU_WAIT);

    // Priority: taken branch, then MDU occupancy, then load-use
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        next_state = state;
        next_cnt   = cnt;
        if (!reset) begin
            next_state = RUN;
            next_cnt   = '0;
        end else if (m_branch_taken) begin
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            next_state = RUN;
            next_cnt   = '0;
        end else if (state == RUN) begin
            if (e_mdu_start) begin
                stall_f    = 1'b1;
                stall_d    = 1'b1;
                stall_e    = 1'b1;
                flush_m    = 1'b1;
                next_state = MDU_WAIT;
                next_cnt   = MDU_CNT_W'(MDU_LATENCY - 2);
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end else if (cnt != '0) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
            next_cnt = cnt - 1'b1;
        end else begin
            next_state = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if ((stall_f || stall_d || stall_e) && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if ((flush_d || flush_e || flush_m) && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit with a cycle-level reference model
module tb_hazard_unit;
    import pipeline_pkg::*;

    localparam int LAT = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
    logic       d_uses_rs, d_uses_rt, e_rf_we, e_is_load, e_mdu_start;
    logic       m_rf_we, m_branch_taken, w_rf_we;

    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy;
    fwd_sel_t    fwd_a, fwd_b;
    logic [31:0] stall_count, flush_count;

    logic        s4_f, s4_d, s4_e, f4_d, f4_e, f4_m, busy4;
    fwd_sel_t    fa4, fb4;
    logic [3:0]  stall_count4, flush_count4;

    int     checks = 0;
    int     fails  = 0;
    int     m_age;
    longint m_stalls, m_flushes;

    always #5 clock = ~clock;

    hazard_unit #(.RF_ADDR_W(5), .MDU_LATENCY(LAT), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .e_rs(e_rs), .e_rt(e_rt), .e_wa(e_wa), .e_rf_we(e_rf_we),
        .e_is_load(e_is_load), .e_mdu_start(e_mdu_start),
        .m_wa(m_wa), .m_rf_we(m_rf_we), .m_branch_taken(m_branch_taken),
        .w_wa(w_wa), .w_rf_we(w_rf_we),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_unit #(.RF_ADDR_W(5), .MDU_LATENCY(LAT), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .e_rs(e_rs), .e_rt(e_rt), .e_wa(e_wa), .e_rf_we(e_rf_we),
        .e_is_load(e_is_load), .e_mdu_start(e_mdu_start),
        .m_wa(m_wa), .m_rf_we(m_rf_we), .m_branch_taken(m_branch_taken),
        .w_wa(w_wa), .w_rf_we(w_rf_we),
        .stall_f(s4_f), .stall_d(s4_d), .stall_e(s4_e),
        .flush_d(f4_d), .flush_e(f4_e), .flush_m(f4_m),
        .fwd_a(fa4), .fwd_b(fb4), .mdu_busy(busy4),
        .stall_count(stall_count4), .flush_count(flush_count4)
    );

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (m_rf_we && m_wa != 0 && m_wa == src) return 2'd1;
        if (w_rf_we && w_wa != 0 && w_wa == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [10:0] dut_vec();
        return {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, fwd_a, fwd_b};
    endfunction

    // m_age counts cycles since the MDU op entered E (0 = none outstanding)
    function automatic logic [10:0] model_vec();
        logic       load_use, mdu_stall;
        logic [5:0] sf;
        if (!reset) return 11'd0;
        load_use  = e_is_load && e_rf_we && e_wa != 0 &&
                    ((d_uses_rs && d_rs == e_wa) || (d_uses_rt && d_rt == e_wa));
        mdu_stall = (m_age == 0 && e_mdu_start) || (m_age >= 1 && m_age <= LAT - 2);
        if (m_branch_taken)           sf = 6'b000110;
        else if (mdu_stall)           sf = 6'b111001;
        else if (m_age == 0 && load_use) sf = 6'b110010;
        else                          sf = 6'b000000;
        return {sf, (m_age >= 1), ref_fwd(e_rs), ref_fwd(e_rt)};
    endfunction

    task automatic tick();
        logic [10:0] v;
        v = model_vec();
        if (!reset) begin
            m_age = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (v[10:8] != 0) m_stalls++;
            if (v[7:5] != 0)  m_flushes++;
            if (m_branch_taken)        m_age = 0;
            else if (m_age == 0)       m_age = e_mdu_start ? 1 : 0;
            else if (m_age == LAT - 1) m_age = 0;
            else                       m_age = m_age + 1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        {d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa} = '0;
        {d_uses_rs, d_uses_rt, e_rf_we, e_is_load, e_mdu_start} = '0;
        {m_rf_we, m_branch_taken, w_rf_we} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_load_use();
        e_is_load = 1; e_rf_we = 1; e_wa = 5'd8; d_rs = 5'd8; d_uses_rs = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0; m_rf_we = 1; m_wa = 5'd3; e_rs = 5'd3;
        #1;
        checks++;
        if (dut_vec() !== 11'd0) begin
            $display("FAIL reset_outputs: got %b want %b", dut_vec(), 11'd0); fails++;
        end
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if ({dut_vec(), stall_count, flush_count} !== {11'd0, 64'd0}) begin
            $display("FAIL reset_state: vec %b stall %0d flush %0d want zeros",
                     dut_vec(), stall_count, flush_count); fails++;
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        e_rs = 5; m_wa = 5; m_rf_we = 1; w_wa = 5; w_rf_we = 1; #1;
        checks++;
        if (fwd_a !== FWD_M) begin $display("FAIL fwd_m_wins: got %0d want %0d", fwd_a, FWD_M); fails++; end
        m_rf_we = 0; #1;
        checks++;
        if (fwd_a !== FWD_W) begin $display("FAIL fwd_w: got %0d want %0d", fwd_a, FWD_W); fails++; end
        e_rs = 0; m_wa = 0; m_rf_we = 1; w_wa = 0; #1;
        checks++;
        if (fwd_a !== FWD_RF) begin $display("FAIL fwd_r0: got %0d want %0d", fwd_a, FWD_RF); fails++; end
        e_rt = 7; w_wa = 7; m_wa = 6; #1;
        checks++;
        if ({fwd_a, fwd_b} !== {FWD_RF, FWD_W}) begin
            $display("FAIL fwd_b: got %0d/%0d want %0d/%0d", fwd_a, fwd_b, FWD_RF, FWD_W); fails++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(); #1;
        checks++;
        if (dut_vec() !== 11'b110_010_0_00_00) begin
            $display("FAIL load_use_stall: got %b want %b", dut_vec(), 11'b110_010_0_00_00); fails++;
        end
        tick();
        e_is_load = 0; e_rf_we = 0; e_wa = 0; #1;
        checks++;
        if ({dut_vec(), stall_count, flush_count} !== {11'd0, 32'd1, 32'd1}) begin
            $display("FAIL load_use_release: vec %b stall %0d flush %0d want 0/1/1",
                     dut_vec(), stall_count, flush_count); fails++;
        end
    endtask

    task automatic test_mdu();
        do_reset();
        e_mdu_start = 1;
        for (int i = 0; i < LAT; i++) begin
            #1;
            checks++;
            if ({stall_e, mdu_busy} !== {(i < LAT - 1), (i >= 1)}) begin
                $display("FAIL mdu_cycle%0d: stall_e %b busy %b want %b %b",
                         i, stall_e, mdu_busy, (i < LAT - 1), (i >= 1)); fails++;
            end
            tick();
        end
        e_mdu_start = 0; #1;
        checks++;
        if ({mdu_busy, stall_f, stall_count, flush_count} !== {2'b00, 32'd3, 32'd3}) begin
            $display("FAIL mdu_done: busy %b stall_f %b stalls %0d flushes %0d want 0 0 3 3",
                     mdu_busy, stall_f, stall_count, flush_count); fails++;
        end
    endtask

    task automatic test_abort();
        do_reset();
        e_mdu_start = 1;
        tick();
        tick();
        m_branch_taken = 1; #1;
        checks++;
        if (dut_vec() !== 11'b000_110_1_00_00) begin
            $display("FAIL abort_flush: got %b want %b", dut_vec(), 11'b000_110_1_00_00); fails++;
        end
        tick();
        m_branch_taken = 0; e_mdu_start = 0; #1;
        checks++;
        if (dut_vec() !== 11'd0) begin
            $display("FAIL abort_run: got %b want %b", dut_vec(), 11'd0); fails++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_load_use(); m_branch_taken = 1; #1;
        checks++;
        if (dut_vec() !== 11'b000_110_0_00_00) begin
            $display("FAIL lu_and_br: got %b want %b", dut_vec(), 11'b000_110_0_00_00); fails++;
        end
        tick();
        m_branch_taken = 0; e_mdu_start = 1; #1;
        checks++;
        if (dut_vec() !== 11'b111_001_0_00_00) begin
            $display("FAIL lu_and_mdu: got %b want %b", dut_vec(), 11'b111_001_0_00_00); fails++;
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        #1;
        checks++;
        if ({stall_count4, flush_count4, stall_count} !== {4'd15, 4'd15, 32'd20}) begin
            $display("FAIL saturate: narrow %0d/%0d wide %0d want 15/15/20",
                     stall_count4, flush_count4, stall_count); fails++;
        end
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        e_mdu_start = 1;
        tick();
        tick();
        reset = 0; m_rf_we = 1; m_wa = 4; e_rs = 4; #1;
        checks++;
        if (dut_vec() !== 11'd0) begin
            $display("FAIL reset_mid_mdu_out: got %b want %b", dut_vec(), 11'd0); fails++;
        end
        tick();
        reset = 1; clear_inputs(); #1;
        checks++;
        if ({dut_vec(), stall_count, flush_count} !== {11'd0, 64'd0}) begin
            $display("FAIL reset_mid_mdu_state: vec %b stall %0d flush %0d want zeros",
                     dut_vec(), stall_count, flush_count); fails++;
        end
    endtask

    task automatic test_random();
        logic [10:0] exp_v;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 59) != 0);
            d_rs           = 5'($urandom_range(0, 3));
            d_rt           = 5'($urandom_range(0, 3));
            e_rs           = 5'($urandom_range(0, 3));
            e_rt           = 5'($urandom_range(0, 3));
            e_wa           = 5'($urandom_range(0, 3));
            m_wa           = 5'($urandom_range(0, 3));
            w_wa           = 5'($urandom_range(0, 3));
            d_uses_rs      = 1'($urandom);
            d_uses_rt      = 1'($urandom);
            e_rf_we        = 1'($urandom);
            e_is_load      = 1'($urandom);
            m_rf_we        = 1'($urandom);
            w_rf_we        = 1'($urandom);
            e_mdu_start    = (m_age != 0) ? 1'b1 : ($urandom_range(0, 6) == 0);
            m_branch_taken = ($urandom_range(0, 14) == 0);
            #1;
            exp_v = model_vec();
            checks++;
            if (dut_vec() !== exp_v) begin
                $display("FAIL rand_outputs[%0d]: got %b want %b", n, dut_vec(), exp_v); fails++;
            end
            checks++;
            if ({stall_count, flush_count} !== {m_stalls[31:0], m_flushes[31:0]}) begin
                $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d",
                         n, stall_count, flush_count, m_stalls, m_flushes); fails++;
            end
            tick();
        end
    endtask

    initial begin
        m_age = 0; m_stalls = 0; m_flushes = 0;
        reset = 1'b0;
        clear_inputs();
        @(negedge clock);
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_abort();
        test_simultaneous();
        test_saturation();
        test_reset_mid_mdu();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
